// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the uart_rx_byte receiver.
//  - 8-bit state codes (same code style as the downstream command decoder)
//  - divider / half-bit / counter-width helper functions
// Config macro: UART_RX_PARITY_EN adds the PARITY state code.
package uart_rx_pkg;

   localparam logic [7:0] ST_IDLE_C   = 8'h01;
   localparam logic [7:0] ST_START_C  = 8'h02;
   localparam logic [7:0] ST_DATA_C   = 8'h04;
   localparam logic [7:0] ST_PARITY_C = 8'h08;
   localparam logic [7:0] ST_STOP_C   = 8'h10;
   localparam logic [7:0] ST_BREAK_C  = 8'h20;

   typedef enum logic [7:0] {
      ST_IDLE   = ST_IDLE_C,
      ST_START  = ST_START_C,
      ST_DATA   = ST_DATA_C,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = ST_PARITY_C,
`endif
      ST_STOP   = ST_STOP_C,
      ST_BREAK  = ST_BREAK_C
   } state_t;

   // Clocks per oversample tick (integer floor).
   function automatic int calc_div(input int clk_hz, input int baud, input int os);
      return clk_hz / (baud * os);
   endfunction

   // Tick index, counted from the start edge, that lands on mid start bit.
   function automatic int calc_half_bit(input int os);
      return os / 2 - 1;
   endfunction

   // Width of a counter holding 0..n-1 (at least 1 bit).
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Receiver-side bundle: serial line in, byte/strobe/error outputs.
//  slave  : the receiver (uart_rx_byte)
//  master : line driver / byte consumer
interface uart_rx_byte_if;
   logic       iRx;
   logic [7:0] omData;
   logic       omData_Ready;
   logic       oFrame_Err;
   logic       oParity_Err;

   modport slave  (input  iRx, output omData, omData_Ready, oFrame_Err, oParity_Err);
   modport master (output iRx, input  omData, omData_Ready, oFrame_Err, oParity_Err);
endinterface

// File: rtl/uart_rx_byte_baud_tick_gen.sv
// Oversample tick generator: oTick is a 1-clock pulse every DIV clocks.
// iClr restarts the period so ticks are phase-aligned to the start edge.
// Ports: iClk, iRst (async, active-high), iClr, oTick.
module baud_tick_gen
   import uart_rx_pkg::*;
#(
   parameter int DIV = 27
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iClr,
   output logic oTick
);
   localparam int CW = cnt_width(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         cnt   <= '0;
         oTick <= 1'b0;
      end else if (iClr) begin
         cnt   <= '0;
         oTick <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         oTick <= 1'b1;
      end else begin
         cnt   <= cnt + 1'b1;
         oTick <= 1'b0;
      end
   end
endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling serial byte receiver (8N1, or 8E1 with UART_RX_PARITY_EN).
// Ports: iClk, iRst (async, active-high), bus (uart_rx_byte_if.slave):
//  iRx line in; omData last good byte; omData_Ready registered pulse of
//  READY_CYCLES clocks; oFrame_Err / oParity_Err 1-clock error pulses.
// Config macro: UART_RX_PARITY_EN (even parity bit before stop bit).
module uart_rx_byte
   import uart_rx_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BAUD         = 115200,
   parameter int OVERSAMPLE   = 16,
   parameter int READY_CYCLES = 4
) (
   input  logic           iClk,
   input  logic           iRst,
   uart_rx_byte_if.slave  bus
);
   localparam int DIV      = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
   localparam int HALF_BIT = calc_half_bit(OVERSAMPLE);
   localparam int TW       = cnt_width(OVERSAMPLE);
   localparam int RW       = cnt_width(READY_CYCLES);
   localparam logic [TW-1:0] HALF_T = TW'(HALF_BIT);
   localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);

   logic          rx_m, rx_s, rx_d;
   state_t        state_q, state_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    data_q;
   logic          rdy_q;
   logic [RW-1:0] rcnt_q;
   logic          ferr_q, ferr_d;
   logic          tick, clr, load;
   logic          half_pt, mid_pt;
`ifdef UART_RX_PARITY_EN
   logic          par_err_q, par_err_d;
   logic          perr_q, perr_d;
`endif

   baud_tick_gen #(.DIV(DIV)) u_tick (
      .iClk  (iClk),
      .iRst  (iRst),
      .iClr  (clr),
      .oTick (tick)
   );

   // rx_m/rx_s: metastability synchroniser; rx_d: one-clock history of
   // rx_s for falling-edge detection. All idle high.
   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= bus.iRx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign half_pt = tick && (tcnt_q == HALF_T);
   assign mid_pt  = tick && (tcnt_q == LAST_T);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      bidx_d  = bidx_q;
      shift_d = shift_q;
      clr     = 1'b0;
      load    = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_d = par_err_q;
      perr_d    = 1'b0;
`endif
      // Tick counter free-runs within a bit; every sample point reloads it.
      if (tick) tcnt_d = tcnt_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (rx_d && !rx_s) begin
               state_d = ST_START;
               tcnt_d  = '0;
               clr     = 1'b1;
            end
         end
         ST_START: begin
            if (half_pt) begin
               tcnt_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;     // short glitch, silently dropped
               end else begin
                  state_d = ST_DATA;
                  bidx_d  = '0;
`ifdef UART_RX_PARITY_EN
                  par_err_d = 1'b0;
`endif
               end
            end
         end
         ST_DATA: begin
            if (mid_pt) begin
               tcnt_d  = '0;
               shift_d = {rx_s, shift_q[7:1]};
               if (bidx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bidx_d = bidx_q + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (mid_pt) begin
               tcnt_d    = '0;
               par_err_d = rx_s ^ (^shift_q);
               state_d   = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (mid_pt) begin
               tcnt_d = '0;
               if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                  perr_d = par_err_q;
                  load   = !par_err_q;
`else
                  load   = 1'b1;
`endif
                  state_d = ST_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            // Only one frame error per low period: wait for the line to recover.
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         tcnt_q  <= '0;
         bidx_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         rcnt_q  <= '0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_err_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         tcnt_q  <= tcnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_err_q <= par_err_d;
         perr_q    <= perr_d;
`endif
         // Ready strobe is timed independently of the FSM so the next frame
         // can already be shifting in while it is high.
         if (load) begin
            data_q <= shift_q;
            rdy_q  <= 1'b1;
            rcnt_q <= RW'(READY_CYCLES - 1);
         end else if (rdy_q) begin
            if (rcnt_q == '0) rdy_q  <= 1'b0;
            else              rcnt_q <= rcnt_q - 1'b1;
         end
      end
   end

   assign bus.omData       = data_q;
   assign bus.omData_Ready = rdy_q;
   assign bus.oFrame_Err   = ferr_q;
`ifdef UART_RX_PARITY_EN
   assign bus.oParity_Err  = perr_q;
`else
   assign bus.oParity_Err  = 1'b0;
`endif

endmodule
